// File: rtl/test_cond_pkg.sv
// Shared condition-test definitions: op encodings, flag bit positions, and the op evaluator.
package test_cond_pkg;

  localparam logic [2:0] COND_EQ = 3'd0;
  localparam logic [2:0] COND_NE = 3'd1;
  localparam logic [2:0] COND_LT = 3'd2;
  localparam logic [2:0] COND_GT = 3'd3;
  localparam logic [2:0] COND_LE = 3'd4;
  localparam logic [2:0] COND_GE = 3'd5;
  localparam logic [2:0] COND_EV = 3'd6;
  localparam logic [2:0] COND_OD = 3'd7;

  // Flag vector layout is {N, Z, O}.
  localparam int FLAG_N = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_O = 0;

  function automatic logic cond_eval(input logic [2:0] op, input logic [2:0] flags);
    logic n, z, o;
    n = flags[FLAG_N];
    z = flags[FLAG_Z];
    o = flags[FLAG_O];
    case (op)
      COND_EQ: cond_eval = z;
      COND_NE: cond_eval = ~z;
      COND_LT: cond_eval = n;
      COND_GT: cond_eval = ~n & ~z;
      COND_LE: cond_eval = n | z;
      COND_GE: cond_eval = ~n;
      COND_EV: cond_eval = ~o;
      default: cond_eval = o;
    endcase
  endfunction

endpackage

// File: rtl/test_cond_flags.sv
// Combinational extraction of sign (N), zero (Z) and parity/LSB (O) flags.
module test_cond_flags
  import test_cond_pkg::*;
#(
  parameter int WIDTH = 24
) (
  input  logic [WIDTH-1:0] a,
  output logic [2:0]       flags
);

  always_comb begin
    flags         = '0;
    flags[FLAG_N] = a[WIDTH-1];
    flags[FLAG_Z] = (a == '0);
    flags[FLAG_O] = a[0];
  end

endmodule

// File: rtl/test_cond_24bit.sv
// Condition-test unit: combinational y plus a registered copy with valid strobe.
// Optional TEST_COND_FLAGS_EN adds a registered {N, Z, O} flags_r output.
module test_cond_24bit
  import test_cond_pkg::*;
#(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [2:0]       op,
  input  logic             valid_in,
  output logic             y,
  output logic             y_r,
  output logic             valid_out
`ifdef TEST_COND_FLAGS_EN
  , output logic [2:0]     flags_r
`endif
);

  logic [2:0] flags;

  test_cond_flags #(.WIDTH(WIDTH)) u_flags (
    .a     (a),
    .flags (flags)
  );

  assign y = cond_eval(op, flags);

  // y_r only captures on valid beats so downstream sees the last valid result.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_out <= 1'b0;
      y_r       <= 1'b0;
    end else begin
      valid_out <= valid_in;
      if (valid_in) y_r <= y;
    end
  end

`ifdef TEST_COND_FLAGS_EN
  always_ff @(posedge clk) begin
    if (rst)           flags_r <= 3'b000;
    else if (valid_in) flags_r <= flags;
  end
`endif

endmodule

// File: tb/tb_test_cond_24bit.sv
// Scoreboard bench for test_cond_24bit: stimulus pushes expectations, monitor checks y_r/valid_out.
module tb_test_cond_24bit;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] a;
  logic [2:0]  op;
  logic        valid_in;
  logic        y, y_r, valid_out;
`ifdef TEST_COND_FLAGS_EN
  logic [2:0]  flags_r;
`endif

  int total = 0;
  int bad   = 0;

  logic [3:0] sb_q[$];  // {y, N, Z, O}

  always #5 clk = ~clk;

  test_cond_24bit dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .op        (op),
    .valid_in  (valid_in),
    .y         (y),
    .y_r       (y_r),
    .valid_out (valid_out)
`ifdef TEST_COND_FLAGS_EN
    , .flags_r (flags_r)
`endif
  );

  function automatic logic [2:0] ref_flags(input logic [23:0] v);
    logic sgn, zro, lsb;
    sgn = v[23];
    zro = (v == 24'd0);
    lsb = v[0];
    return {sgn, zro, lsb};
  endfunction

  function automatic logic ref_y(input logic [2:0] o, input logic [23:0] v);
    logic sgn, zro, lsb;
    sgn = v[23];
    zro = (v == 24'd0);
    lsb = v[0];
    if (o == 3'd0) return zro;
    if (o == 3'd1) return !zro;
    if (o == 3'd2) return sgn;
    if (o == 3'd3) return !sgn && !zro;
    if (o == 3'd4) return sgn || zro;
    if (o == 3'd5) return !sgn;
    if (o == 3'd6) return !lsb;
    return lsb;
  endfunction

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one beat; check combinational y, and queue the registered expectation.
  task automatic issue(input logic [23:0] av, input logic [2:0] opv, input logic ey);
    @(negedge clk);
    a = av; op = opv; valid_in = 1'b1;
    #1;
    chk($sformatf("y op=%0d a=%h", opv, av), {3'b0, y}, {3'b0, ey});
    sb_q.push_back({ey, ref_flags(av)});
  endtask

  // Monitor: pops one expectation per valid_out beat.
  always @(negedge clk) begin
    if (valid_out === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("unexpected valid_out", 4'd1, 4'd0);
      end else begin
        logic [3:0] e;
        e = sb_q.pop_front();
        chk("y_r", {3'b0, y_r}, {3'b0, e[3]});
`ifdef TEST_COND_FLAGS_EN
        chk("flags_r", {1'b0, flags_r}, {1'b0, e[2:0]});
`endif
      end
    end
  end

  logic [23:0] dv_a [15] = '{24'h000000, 24'h000000, 24'h000001, 24'hF010FF, 24'h7010FF,
                             24'hF010FF, 24'h7010FF, 24'h000000, 24'h7010FF, 24'hF010FF,
                             24'h7010FF, 24'hF010FF, 24'hF010FE, 24'hF010FE, 24'hF010FF};
  logic [2:0]  dv_op[15] = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd4, 3'd4,
                             3'd5, 3'd5, 3'd6, 3'd6, 3'd7, 3'd7};
  logic        dv_y [15] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0,
                             1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [23:0] sw_a [6]  = '{24'h000000, 24'h000001, 24'hFFFFFF, 24'h7FFFFF,
                             24'h800000, 24'h000002};

  initial begin
    rst = 1'b1; valid_in = 1'b0; a = '0; op = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset y_r", {3'b0, y_r}, 4'd0);
    chk("reset valid_out", {3'b0, valid_out}, 4'd0);
`ifdef TEST_COND_FLAGS_EN
    chk("reset flags_r", {1'b0, flags_r}, 4'd0);
`endif
    rst = 1'b0;

    for (int i = 0; i < 15; i++) issue(dv_a[i], dv_op[i], dv_y[i]);

    // Boundary sweep against the flag equations.
    for (int i = 0; i < 6; i++)
      for (int k = 0; k < 8; k++)
        issue(sw_a[i], 3'(k), ref_y(3'(k), sw_a[i]));

    // Registered path: capture, hold, then reset-over-valid.
    issue(24'h800000, 3'd2, 1'b1);
    @(negedge clk);
    a = 24'h000000; op = 3'd2; valid_in = 1'b0;
    @(negedge clk);
    chk("hold y_r", {3'b0, y_r}, 4'd1);
    chk("hold valid_out", {3'b0, valid_out}, 4'd0);
    a = 24'h800000; op = 3'd2; valid_in = 1'b1; rst = 1'b1;
    @(negedge clk);
    chk("rst y_r", {3'b0, y_r}, 4'd0);
    chk("rst valid_out", {3'b0, valid_out}, 4'd0);
`ifdef TEST_COND_FLAGS_EN
    chk("rst flags_r", {1'b0, flags_r}, 4'd0);
`endif
    rst = 1'b0; valid_in = 1'b0;

    for (int c = 0; c < 10 && sb_q.size() != 0; c++) @(negedge clk);
    chk("scoreboard drained", 4'(sb_q.size()), 4'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
